// File: rtl/uart_word_sender_if.sv
// Signal bundle between user logic, uart_word_sender and the UART transmitter.
// master = the word sender, slave = user logic plus transmitter as seen from outside.
interface uart_word_sender_if;
    logic [15:0] word_in;
    logic        send;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_en;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  word_in, send, tx_busy,
        output tx_data, tx_wr, tx_en, busy, done, err
    );

    modport slave (
        output word_in, send, tx_busy,
        input  tx_data, tx_wr, tx_en, busy, done, err
    );
endinterface

// File: rtl/uart_word_sender.sv
// Sends a latched 16-bit word to a byte-wide UART transmitter, low byte first,
// with a programmable idle gap between bytes and a watchdog on the transmitter busy rise.
module uart_word_sender #(
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    uart_word_sender_if.master bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : {GW{1'b0}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR0   = 3'd1,
        RISE0 = 3'd2,
        FALL0 = 3'd3,
        GAP   = 3'd4,
        WR1   = 3'd5,
        RISE1 = 3'd6,
        FALL1 = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   wreg_q, wreg_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic          tx_en_q, tx_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_inc_s;
    logic [GW-1:0] gap_inc_s;

    // Saturating increments: neither counter may wrap back to zero.
    always_comb begin
        timer_inc_s = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + {{(TW-1){1'b0}}, 1'b1};
        gap_inc_s   = (gap_q == {GW{1'b1}})   ? gap_q   : gap_q + {{(GW-1){1'b0}}, 1'b1};
    end

    // Next-state and registered-output logic of the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        wreg_d    = wreg_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        tx_en_d   = tx_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    wreg_d  = bus.word_in;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    tx_en_d = 1'b1;
                    state_d = WR0;
                end else begin
                    busy_d  = 1'b0;
                    tx_en_d = 1'b0;
                end
            end
            WR0, WR1: begin
                tx_data_d = (state_q == WR0) ? wreg_q[7:0] : wreg_q[15:8];
                tx_wr_d   = 1'b1;
                timer_d   = {TW{1'b0}};
                state_d   = (state_q == WR0) ? RISE0 : RISE1;
            end
            RISE0, RISE1: begin
                if (bus.tx_busy) begin
                    state_d = (state_q == RISE0) ? FALL0 : FALL1;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    tx_en_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            FALL0: begin
                // The byte boundary is the busy fall; the rise only confirms acceptance.
                if (!bus.tx_busy) begin
                    gap_d   = {GW{1'b0}};
                    state_d = (GAP_CYCLES > 0) ? GAP : WR1;
                end else begin
                    state_d = FALL0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = WR1;
                end else begin
                    gap_d = gap_inc_s;
                end
            end
            FALL1: begin
                if (!bus.tx_busy) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    tx_en_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = FALL1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                tx_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wreg_q    <= 16'h0000;
            timer_q   <= {TW{1'b0}};
            gap_q     <= {GW{1'b0}};
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wreg_q    <= wreg_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_wr   = tx_wr_q;
    assign bus.tx_en   = tx_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_uart_word_sender.sv
// Scoreboard bench: dut_a (gap 16, busy timeout 8) and dut_b (gap 0, timeout 1024),
// each driven by a transmitter model that holds tx_busy for 10 cycles per byte.
module tb_uart_word_sender;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fall_cyc [2];
    bit   tie_low  [2];

    typedef struct {
        logic [7:0] data;
        int         at_cyc;
        int         gap;
    } byte_t;

    typedef struct {
        bit is_done;
        int at_cyc;
    } end_t;

    byte_t exp_byte_a[$];
    byte_t exp_byte_b[$];
    end_t  exp_end_a[$];
    end_t  exp_end_b[$];

    uart_word_sender_if ifa();
    uart_word_sender_if ifb();

    uart_word_sender #(.GAP_CYCLES(16), .BUSY_TIMEOUT(8)) dut_a (
        .clk(clk), .reset(rst), .bus(ifa)
    );
    uart_word_sender #(.GAP_CYCLES(0), .BUSY_TIMEOUT(1024)) dut_b (
        .clk(clk), .reset(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // {tx_data[12:5], tx_wr[4], tx_en[3], busy[2], done[1], err[0]}
    function automatic logic [12:0] outs(input int d);
        if (d == 0) return {ifa.tx_data, ifa.tx_wr, ifa.tx_en, ifa.busy, ifa.done, ifa.err};
        else        return {ifb.tx_data, ifb.tx_wr, ifb.tx_en, ifb.busy, ifb.done, ifb.err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic s, input logic [15:0] w);
        if (d == 0) begin ifa.send = s; ifa.word_in = w; end
        else        begin ifb.send = s; ifb.word_in = w; end
    endtask

    task automatic set_busy(input int d, input logic v);
        if (d == 0) ifa.tx_busy = v;
        else        ifb.tx_busy = v;
    endtask

    task automatic push_byte(input int d, input logic [7:0] data, input int at_cyc, input int gap);
        byte_t e;
        e = '{data, at_cyc, gap};
        if (d == 0) exp_byte_a.push_back(e);
        else        exp_byte_b.push_back(e);
    endtask

    task automatic push_end(input int d, input bit is_done, input int at_cyc);
        end_t n;
        n = '{is_done, at_cyc};
        if (d == 0) exp_end_a.push_back(n);
        else        exp_end_b.push_back(n);
    endtask

    task automatic pop_byte(input int d, output bit have, output byte_t e);
        e = '{8'h00, -1, -1};
        if (d == 0) begin
            have = (exp_byte_a.size() > 0);
            if (have) e = exp_byte_a.pop_front();
        end else begin
            have = (exp_byte_b.size() > 0);
            if (have) e = exp_byte_b.pop_front();
        end
    endtask

    task automatic pop_end(input int d, output bit have, output end_t n);
        n = '{1'b0, -1};
        if (d == 0) begin
            have = (exp_end_a.size() > 0);
            if (have) n = exp_end_a.pop_front();
        end else begin
            have = (exp_end_b.size() > 0);
            if (have) n = exp_end_b.pop_front();
        end
    endtask

    function automatic int pending(input int d);
        if (d == 0) return exp_byte_a.size() + exp_end_a.size();
        else        return exp_byte_b.size() + exp_end_b.size();
    endfunction

    // Transmitter model: tx_busy rises on the tx_wr cycle and stays high for 10 clocks.
    task automatic tx_model(input int d);
        logic [12:0] o;
        forever begin
            @(posedge clk);
            #1;
            o = outs(d);
            if (o[4] && !tie_low[d]) begin
                set_busy(d, 1'b1);
                repeat (10) @(posedge clk);
                #1;
                set_busy(d, 1'b0);
                fall_cyc[d] = cyc + 1;
            end
        end
    endtask

    task automatic monitor(input int d);
        logic [12:0] o;
        logic        prev_wr = 1'b0;
        logic        prev_err = 1'b0;
        bit          have;
        byte_t       e;
        end_t        n;
        forever begin
            @(negedge clk);
            o = outs(d);
            if (o[4]) begin
                check($sformatf("d%0d tx_wr_single_cycle", d), 32'(prev_wr), 32'd0);
                pop_byte(d, have, e);
                check($sformatf("d%0d tx_wr_expected", d), 32'(have), 32'd1);
                if (have) begin
                    check($sformatf("d%0d tx_data", d), 32'(o[12:5]), 32'(e.data));
                    if (e.at_cyc >= 0) check($sformatf("d%0d byte0_latency", d), cyc, e.at_cyc);
                    if (e.gap >= 0) check($sformatf("d%0d byte1_gap", d), cyc - fall_cyc[d], e.gap);
                end
            end
            if (o[1] || (o[0] && !prev_err)) begin
                pop_end(d, have, n);
                check($sformatf("d%0d end_expected", d), 32'(have), 32'd1);
                if (have) begin
                    check($sformatf("d%0d end_is_done", d), 32'(o[1]), 32'(n.is_done));
                    check($sformatf("d%0d end_busy_en_low", d), 32'({o[3], o[2]}), 32'd0);
                    if (n.at_cyc >= 0) check($sformatf("d%0d end_time", d), cyc, n.at_cyc);
                    if (o[1]) check($sformatf("d%0d done_err_clear", d), 32'(o[0]), 32'd0);
                end
            end
            prev_wr  = o[4];
            prev_err = o[0];
        end
    endtask

    // Queue the two bytes and the done pulse of a normal transfer, then pulse send.
    task automatic send_word(input int d, input logic [15:0] w, input int gap_exp);
        push_byte(d, w[7:0], cyc + 2, -1);
        push_byte(d, w[15:8], -1, gap_exp);
        push_end(d, 1'b1, -1);
        drive(d, 1'b1, w);
        tick();
        drive(d, 1'b0, 16'h0000);
    endtask

    task automatic wait_end(input int d, input string name);
        bit ok = 1'b0;
        logic [12:0] o;
        for (int i = 0; i < 600; i++) begin
            o = outs(d);
            if (pending(d) == 0 && o[2] == 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({name, " completes"}, 32'(ok), 32'd1);
        repeat (3) tick();
    endtask

    initial tx_model(0);
    initial tx_model(1);
    initial monitor(0);
    initial monitor(1);

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [12:0] o;
        bit found;
        tie_low[0] = 1'b0;
        tie_low[1] = 1'b0;
        fall_cyc[0] = 0;
        fall_cyc[1] = 0;
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        set_busy(0, 1'b0);
        set_busy(1, 1'b0);
        repeat (3) tick();
        check("a reset outputs", 32'(outs(0)), 32'd0);
        check("b reset outputs", 32'(outs(1)), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // tx_busy high in IDLE does nothing
        ifa.tx_busy = 1'b1;
        repeat (4) tick();
        check("a idle ignores tx_busy", 32'(outs(0)), 32'd0);
        ifa.tx_busy = 1'b0;
        tick();

        // 1: normal word, 16-cycle gap
        send_word(0, 16'hA55A, 17);
        wait_end(0, "t1");
        o = outs(0);
        check("t1 err after done", 32'(o[0]), 32'd0);

        // 2: zero gap on dut_b
        send_word(1, 16'h00FF, 1);
        wait_end(1, "t2");

        // 3: tx_busy tied low -> timeout, then a clean transfer clears err
        tie_low[0] = 1'b1;
        push_byte(0, 8'h78, cyc + 2, -1);
        push_end(0, 1'b0, cyc + 10);
        drive(0, 1'b1, 16'h5678);
        tick();
        drive(0, 1'b0, 16'h0000);
        wait_end(0, "t3 timeout");
        repeat (3) tick();
        o = outs(0);
        check("t3 err sticky", 32'(o[0]), 32'd1);
        check("t3 busy/tx_en low", 32'({o[3], o[2]}), 32'd0);
        tie_low[0] = 1'b0;
        send_word(0, 16'h1234, 17);
        o = outs(0);
        check("t3 err cleared by accept", 32'(o[0]), 32'd0);
        wait_end(0, "t3 resend");

        // 4: sends with a new word_in during a transfer are ignored
        send_word(0, 16'hC0DE, 17);
        for (int k = 0; k < 4; k++) begin
            repeat (7) tick();
            drive(0, 1'b1, 16'hFFFF);
            tick();
            drive(0, 1'b0, 16'hFFFF);
        end
        wait_end(0, "t4");

        // 5: reset while waiting for byte 1's busy rise
        push_byte(0, 8'h0F, cyc + 2, -1);
        push_byte(0, 8'hF0, -1, 17);
        drive(0, 1'b1, 16'hF00F);
        tick();
        drive(0, 1'b0, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            o = outs(0);
            if (o[4] && o[12:5] == 8'hF0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t5 reached byte1 write", 32'(found), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5 async reset outputs", 32'(outs(0)), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ifa.tx_busy == 1'b0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t5 transmitter idle", 32'(found), 32'd1);
        repeat (2) tick();
        check("t5 idle after reset", 32'(outs(0)), 32'd0);
        send_word(0, 16'hBEEF, 17);
        wait_end(0, "t5 resend");

        repeat (5) tick();
        check("a leftover expectations", pending(0), 32'd0);
        check("b leftover expectations", pending(1), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
